regfile_dump_reader: RTL

Debug read-out engine for the 32×32 register file. On a start command it requests a write hold from the core and walks register addresses FIRST_REG..LAST_REG through a dedicated combinational read port. Each word, with its index, is streamed out on a valid/ready channel toward the debug/UART bridge. It is the reader counterpart of the datapath write port: it stalls writeback during a dump so the snapshot is consistent.

---
 rtl/regfile_dump_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine for the register file. A START request raises a write
// hold toward the core, then walks FIRST_REG..LAST_REG through a dedicated
// combinational read port. Each word is streamed with its index on a
// valid/ready channel. DONE pulses for one cycle after the final word is taken.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int ZERO_R0   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              HOLD_REQ,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic [ADDR_W-1:0] DUMP_IDX,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam bit                MASK_R0   = (ZERO_R0 != 0);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              busy_q;

    // idx is returned to FIRST_REG whenever the FSM goes idle, so driving the
    // read address straight from it already yields FIRST_REG in IDLE.
    assign RD_ADDR  = idx;
    assign BUSY     = busy_q;
    assign HOLD_REQ = busy_q;

    // Dump sequencer: walks the index, captures read data and runs the handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            idx        <= FIRST_IDX;
            busy_q     <= 1'b0;
            DONE       <= 1'b0;
            DUMP_VALID <= 1'b0;
            DUMP_DATA  <= '0;
            DUMP_IDX   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        idx    <= FIRST_IDX;
                        busy_q <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (MASK_R0 && (idx == '0)) begin
                        DUMP_DATA <= '0;
                    end else begin
                        DUMP_DATA <= RD_DATA;
                    end
                    DUMP_IDX   <= idx;
                    DUMP_VALID <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (DUMP_READY) begin
                        DUMP_VALID <= 1'b0;
                        if (idx == LAST_IDX) begin
                            idx    <= FIRST_IDX;
                            busy_q <= 1'b0;
                            DONE   <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= READ;
                        end
                    end
                end
                default: begin
                    idx    <= FIRST_IDX;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
